// File: rtl/grayscale_rd_engine.sv
// Purpose: issues CCI-P c0 read requests covering a host source buffer, one cache line per request.
// Latency: first request is registered 2 cycles after start when unthrottled; done 1 cycle after the last response.
// Backpressure: issue pauses on c0tx_almfull, the outstanding-read limit, or insufficient downstream FIFO room.
//
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   start                 one-cycle pulse from the CSR control-word write (honoured only when idle)
//   src_addr, num_lines   source buffer base (cache lines) and length (cache lines)
//   c0tx_valid/addr/mdata registered read request; mdata carries the line index [15:0]
//   c0tx_almfull          CCI-P c0 almost-full
//   c0rx_rd_valid         one read response returned this cycle
//   fifo_count            current occupancy of the downstream pixel FIFO
//   busy, done            engine active / one-cycle completion pulse
//   err_spurious          sticky: a response arrived with nothing outstanding
module grayscale_rd_engine #(
    parameter int MAX_OUTSTANDING = 64,
    parameter int FIFO_DEPTH      = 128,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [41:0]      src_addr,
    input  logic [31:0]      num_lines,
    output logic             c0tx_valid,
    output logic [41:0]      c0tx_addr,
    output logic [15:0]      c0tx_mdata,
    input  logic             c0tx_almfull,
    input  logic             c0rx_rd_valid,
    input  logic [CNT_W-1:0] fifo_count,
    output logic             busy,
    output logic             done,
    output logic             err_spurious
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Limits widened by one bit so the credit sum below cannot wrap.
    localparam logic [CNT_W:0] OUT_LIMIT  = (CNT_W+1)'(MAX_OUTSTANDING);
    localparam logic [CNT_W:0] FIFO_LIMIT = (CNT_W+1)'(FIFO_DEPTH);

    logic [1:0]       state;
    logic [41:0]      base;
    logic [31:0]      total;
    logic [31:0]      issued;
    logic [31:0]      received;
    logic [CNT_W-1:0] outstanding;

    logic             issue_ok;
    logic             rsp_ok;
    logic [CNT_W:0]   credit_sum;
    logic [31:0]      received_nxt;

    // Every outstanding read will land in the downstream FIFO, so reads in
    // flight are counted against its free space alongside its occupancy.
    assign credit_sum = {1'b0, outstanding} + {1'b0, fifo_count};

    assign issue_ok = (state == S_RUN)
                   && (issued < total)
                   && !c0tx_almfull
                   && ({1'b0, outstanding} < OUT_LIMIT)
                   && (credit_sum < FIFO_LIMIT);

    // A response with nothing outstanding is flagged but never counted.
    assign rsp_ok       = c0rx_rd_valid && (outstanding != '0);
    assign received_nxt = received + {31'b0, rsp_ok};

    assign busy = (state == S_RUN) || (state == S_DRAIN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            base         <= '0;
            total        <= '0;
            issued       <= '0;
            received     <= '0;
            outstanding  <= '0;
            c0tx_valid   <= 1'b0;
            c0tx_addr    <= '0;
            c0tx_mdata   <= '0;
            err_spurious <= 1'b0;
        end else begin
            c0tx_valid <= issue_ok;

            // Address and tag hold their last value while issue is paused.
            if (issue_ok) begin
                c0tx_addr  <= base + {10'b0, issued};
                c0tx_mdata <= issued[15:0];
                issued     <= issued + 32'd1;
            end

            if (c0rx_rd_valid && (outstanding == '0)) begin
                err_spurious <= 1'b1;
            end

            if (rsp_ok) begin
                received <= received_nxt;
            end

            // Simultaneous issue and response leave outstanding unchanged.
            case ({issue_ok, rsp_ok})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase

            case (state)
                S_IDLE: begin
                    if (start) begin
                        base        <= src_addr;
                        total       <= num_lines;
                        issued      <= '0;
                        received    <= '0;
                        outstanding <= '0;
                        state       <= (num_lines == 32'd0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    // Leaves one cycle after the final request was registered.
                    if (issued == total) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (received_nxt == total) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
